// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the IF/MEM pipeline stages and the unified memory.
// slave = arbiter side, master = pipeline and memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_rdata;
    logic              if_valid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    logic              stall_if;
    logic              stall_pipe;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_valid,
        output stall_if, stall_pipe,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output mem_err
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid,
        input  stall_if, stall_pipe,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  mem_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-ported memory between fetch and load/store.
// Optional transaction timeout with sticky mem_err is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I
    } state_t;

    state_t            state;
    logic              kill;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [31:0]       if_rdata_q;
    logic              if_valid_q;
    logic              dm_valid_q;
    logic              finish;
    logic              expire;
    logic [31:0]       fetch_word;

    if (TIMEOUT < 1 || DATA_W < 64 || ADDR_W < 3) begin : g_bad_cfg
        $error("mem_port_arbiter: needs TIMEOUT >= 1, DATA_W >= 64, ADDR_W >= 3");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] age;
    logic             err_q;
`endif

    always_comb begin
        expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
        expire = !bus.mem_ready && (age == CNT_W'(TIMEOUT - 1));
`endif
        finish     = bus.mem_ready || expire;
        fetch_word = mem_addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            kill        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            age         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            age <= age + 1'b1;
            if (state != IDLE && expire) err_q <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (bus.dm_req) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        state       <= BUSY_D;
`ifdef ARB_TIMEOUT_EN
                        age         <= '0;
`endif
                    end else if (bus.if_req && !bus.if_flush) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                        state      <= BUSY_I;
`ifdef ARB_TIMEOUT_EN
                        age        <= '0;
`endif
                    end
                end
                BUSY_D: begin
                    if (finish) begin
                        mem_req_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        state      <= IDLE;
                        if (expire)         dm_rdata_q <= '0;
                        else if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
                    end
                end
                BUSY_I: begin
                    if (finish) begin
                        mem_req_q <= 1'b0;
                        kill      <= 1'b0;
                        state     <= IDLE;
                        // A flush landing on the completion cycle kills the fetch as well.
                        if (!(kill || bus.if_flush)) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= expire ? '0 : fetch_word;
                        end
                    end else if (bus.if_flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.dm_valid   = dm_valid_q;
    assign bus.stall_if   = bus.if_req & ~if_valid_q & ~bus.if_flush;
    assign bus.stall_pipe = bus.dm_req & ~dm_valid_q;

`ifdef ARB_TIMEOUT_EN
    assign bus.mem_err = err_q;
`else
    assign bus.mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cycle    = 0;

    // Reference model: the one transaction in flight and the outputs it predicts.
    logic        m_busy = 1'b0, m_is_d = 1'b0, m_we = 1'b0, m_kill = 1'b0, m_rst_seen = 1'b0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    int unsigned m_age = 0;
    logic        e_ifv = 1'b0, e_dmv = 1'b0, e_req = 1'b0, e_err = 1'b0;
    logic [31:0] e_ifr = '0;
    logic [63:0] e_dmr = '0;

    // Memory model: answers mem_lat edges after it first sees mem_req (0 = never).
    int unsigned mem_cnt = 0, mem_lat = 0;
    logic        mem_done = 1'b0, mem_rand_lat = 1'b0, mem_fixed_en = 1'b0;
    logic [63:0] mem_fixed = '0;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mdata;
        int unsigned lat;
        int unsigned exp_cyc;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        logic        p_rst, p_ifreq, p_flush, p_dmreq, p_we, p_ready, p_mreq, tmo;
        logic [63:0] p_ifaddr, p_dmaddr, p_wdata, p_rdata;
        p_rst    = reset;
        p_ifreq  = bus.if_req;
        p_flush  = bus.if_flush;
        p_dmreq  = bus.dm_req;
        p_we     = bus.dm_we;
        p_ready  = bus.mem_ready;
        p_mreq   = bus.mem_req;
        p_ifaddr = bus.if_addr;
        p_dmaddr = bus.dm_addr;
        p_wdata  = bus.dm_wdata;
        p_rdata  = bus.mem_rdata;
        @(posedge clk);
        #1;
        cycle++;

        e_ifv      = 1'b0;
        e_dmv      = 1'b0;
        m_rst_seen = p_rst;
        if (p_rst) begin
            m_busy = 1'b0; m_kill = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            e_req = 1'b0; e_err = 1'b0; e_ifr = '0; e_dmr = '0;
        end else if (!m_busy) begin
            if (p_dmreq) begin
                m_busy = 1'b1; m_is_d = 1'b1; m_we = p_we; m_addr = p_dmaddr; m_wdata = p_wdata;
                m_age = 0; m_kill = 1'b0; e_req = 1'b1;
            end else if (p_ifreq && !p_flush) begin
                m_busy = 1'b1; m_is_d = 1'b0; m_we = 1'b0; m_addr = p_ifaddr;
                m_age = 0; m_kill = 1'b0; e_req = 1'b1;
            end
        end else begin
            m_age++;
            if (!m_is_d && p_flush) m_kill = 1'b1;
            tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (!p_ready && m_age == TO) tmo = 1'b1;
`endif
            if (p_ready || tmo) begin
                m_busy = 1'b0;
                e_req  = 1'b0;
                if (tmo) e_err = 1'b1;
                if (m_is_d) begin
                    e_dmv = 1'b1;
                    if (tmo)        e_dmr = '0;
                    else if (!m_we) e_dmr = p_rdata;
                end else if (!m_kill) begin
                    e_ifv = 1'b1;
                    e_ifr = tmo ? 32'h0 : (m_addr[2] ? p_rdata[63:32] : p_rdata[31:0]);
                end
            end
        end

        if (p_mreq !== 1'b1) begin
            mem_cnt = 0; mem_done = 1'b0; bus.mem_ready = 1'b0;
        end else if (mem_done) begin
            bus.mem_ready = 1'b0;
        end else begin
            if (mem_cnt == 0 && mem_rand_lat) mem_lat = $urandom_range(1, 4);
            mem_cnt++;
            if (mem_lat != 0 && mem_cnt == mem_lat) begin
                bus.mem_ready = 1'b1; mem_done = 1'b1;
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
        bus.mem_rdata = (bus.mem_ready && mem_fixed_en) ? mem_fixed : {$urandom, $urandom};

        check("if_valid",   64'(bus.if_valid),   64'(e_ifv));
        check("dm_valid",   64'(bus.dm_valid),   64'(e_dmv));
        check("if_rdata",   64'(bus.if_rdata),   64'(e_ifr));
        check("dm_rdata",   bus.dm_rdata,        e_dmr);
        check("mem_req",    64'(bus.mem_req),    64'(e_req));
        check("mem_err",    64'(bus.mem_err),    64'(e_err));
        check("stall_if",   64'(bus.stall_if),   64'(bus.if_req & ~e_ifv & ~bus.if_flush));
        check("stall_pipe", 64'(bus.stall_pipe), 64'(bus.dm_req & ~e_dmv));
        if (e_req || m_rst_seen) begin
            check("mem_addr", bus.mem_addr,   m_addr);
            check("mem_we",   64'(bus.mem_we), 64'(m_we));
            if (m_we || m_rst_seen) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
    endtask

    task automatic rand_drive();
        bus.if_flush = 1'b0;
        reset        = 1'b0;
        if (e_ifv) bus.if_req = 1'b0;
        if (e_dmv) bus.dm_req = 1'b0;
        if (!bus.if_req && $urandom_range(0, 2) == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = {32'h0, $urandom} & ~64'h3;
        end else if (bus.if_req && $urandom_range(0, 11) == 0) begin
            bus.if_flush = 1'b1;
            bus.if_addr  = {32'h0, $urandom} & ~64'h3;
            bus.if_req   = 1'($urandom_range(0, 1));
        end
        if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_addr  = {$urandom, $urandom} & ~64'h7;
            bus.dm_wdata = {$urandom, $urandom};
        end else if (bus.dm_req && $urandom_range(0, 39) == 0) begin
            bus.dm_req = 1'b0;
        end
        if ($urandom_range(0, 249) == 0) begin
            reset = 1'b1; bus.if_req = 1'b0; bus.dm_req = 1'b0;
        end
    endtask

    initial begin
        int unsigned n, nv, first, t_d, t_i;
        logic        got;

        vecs[0] = '{1'b0, 1'b0, 64'h4,  64'h0,  64'hDEADBEEF_12345678, 2, 4, 64'h0000_0000_DEADBEEF};
        vecs[1] = '{1'b0, 1'b0, 64'h10, 64'h0,  64'h0BADF00D_CAFEBABE, 1, 3, 64'h0000_0000_CAFEBABE};
        vecs[2] = '{1'b1, 1'b0, 64'h40, 64'h0,  64'h11223344_55667788, 2, 4, 64'h11223344_55667788};
        vecs[3] = '{1'b1, 1'b1, 64'h80, 64'h55, 64'hFFFFFFFF_FFFFFFFF, 3, 5, 64'h11223344_55667788};
        vecs[4] = '{1'b1, 1'b0, 64'h48, 64'h0,  64'hA5A55A5A_0F0FF0F0, 4, 6, 64'hA5A55A5A_0F0FF0F0};
        vecs[5] = '{1'b0, 1'b0, 64'hC,  64'h0,  64'h13579BDF_2468ACE0, 3, 5, 64'h0000_0000_13579BDF};

        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        step();
        step();
        check("rst_mem_req",  64'(bus.mem_req),  64'h0);
        check("rst_if_valid", 64'(bus.if_valid), 64'h0);
        check("rst_dm_rdata", bus.dm_rdata,      64'h0);
        reset = 1'b0;
        step();

        // Single transactions from idle: latency and returned data.
        mem_fixed_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_lat   = vecs[i].lat;
            mem_fixed = vecs[i].mdata;
            if (vecs[i].is_d) begin
                bus.dm_req = 1'b1; bus.dm_we = vecs[i].we;
                bus.dm_addr = vecs[i].addr; bus.dm_wdata = vecs[i].wdata;
            end else begin
                bus.if_req = 1'b1; bus.if_addr = vecs[i].addr;
            end
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                step();
                n++;
                got = vecs[i].is_d ? bus.dm_valid : bus.if_valid;
            end
            bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.dm_we = 1'b0;
            check($sformatf("vec%0d_latency", i), 64'(n), 64'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_rdata", i),
                  vecs[i].is_d ? bus.dm_rdata : 64'(bus.if_rdata), vecs[i].exp_rdata);
            step();
            check($sformatf("vec%0d_one_pulse", i),
                  64'(vecs[i].is_d ? bus.dm_valid : bus.if_valid), 64'h0);
            step();
        end

        // Both requests together: data first, fetch 4 cycles after dm_valid.
        mem_lat = 2; mem_fixed = 64'hCAFED00D_00C0FFEE;
        bus.if_req = 1'b1; bus.if_addr = 64'h0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h40;
        t_d = 0; t_i = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.dm_valid && t_d == 0) begin t_d = k; bus.dm_req = 1'b0; end
            if (bus.if_valid && t_i == 0) begin t_i = k; bus.if_req = 1'b0; end
        end
        check("both_dm_first", 64'(t_d), 64'd4);
        check("both_if_after", 64'(t_i), 64'd8);

        // Flush one cycle into a fetch: killed, then the redirected fetch issues.
        mem_lat = 3; mem_fixed = 64'h77776666_55554444;
        bus.if_req = 1'b1; bus.if_addr = 64'h8;
        step();
        bus.if_flush = 1'b1; bus.if_addr = 64'h100;
        step();
        bus.if_flush = 1'b0;
        nv = 0; first = 0;
        for (int k = 3; k <= 16; k++) begin
            step();
            if (bus.if_valid) begin
                nv++;
                if (first == 0) first = k;
                bus.if_req = 1'b0;
            end
        end
        check("flush_pulses", 64'(nv),    64'd1);
        check("flush_refetch", 64'(first), 64'd10);
        check("flush_rdata", 64'(bus.if_rdata), 64'h55554444);

        // Reset while a load is outstanding.
        mem_lat = 3;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h180;
        step();
        step();
        reset = 1'b1; bus.dm_req = 1'b0;
        step();
        check("midrst_mem_req",  64'(bus.mem_req),  64'h0);
        check("midrst_dm_valid", 64'(bus.dm_valid), 64'h0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Memory never answers.
        mem_lat = 0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h200;
`ifdef ARB_TIMEOUT_EN
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            step();
            n++;
            got = bus.dm_valid;
        end
        bus.dm_req = 1'b0;
        check("tmo_cycle",  64'(n),           64'(TO + 1));
        check("tmo_rdata",  bus.dm_rdata,     64'h0);
        check("tmo_err",    64'(bus.mem_err), 64'h1);
        for (int k = 0; k < 5; k++) step();
        check("tmo_sticky", 64'(bus.mem_err), 64'h1);
        reset = 1'b1;
        step();
        check("tmo_err_clr", 64'(bus.mem_err), 64'h0);
`else
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.dm_valid) nv++;
        end
        check("hang_no_valid", 64'(nv),          64'h0);
        check("hang_mem_req",  64'(bus.mem_req), 64'h1);
        bus.dm_req = 1'b0;
        reset = 1'b1;
        step();
`endif
        reset = 1'b0;
        step();

        // Randomized traffic against the reference model.
        mem_fixed_en = 1'b0;
        mem_rand_lat = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rand_drive();
            step();
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.if_flush = 1'b0; reset = 1'b0;
        for (int k = 0; k < 10; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Fixed priority: MEM-stage data access wins over fetch, because it belongs to the older instruction.
- Sequences each memory transaction with a request/ready handshake and returns results with a one-cycle valid pulse.
- Generates IF and pipeline stall signals so the pipeline registers hold while their access is outstanding.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, memory data width.
- TIMEOUT, 16, cycle limit for a transaction (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_valid or if_flush.
- if_addr  in  ADDR_W  fetch byte address; bit 2 selects the 32-bit word.
- if_flush  in  1  taken-branch flush; cancels the pending fetch.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- dm_req  in  1  data request; held high until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle pulse; load data valid or store complete.
- stall_if  out  1  if_req & ~if_valid & ~if_flush (combinational).
- stall_pipe  out  1  dm_req & ~dm_valid (combinational); freezes IF/ID, ID/EX and EX/MEM.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable, registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_rdata  in  DATA_W  valid when mem_ready is high.
- mem_ready  in  1  one-cycle completion pulse from memory.
- mem_err  out  1  timeout error flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_valid, dm_valid, mem_err = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE:
  - If dm_req: latch dm_addr, dm_we, dm_wdata into the mem_* registers, set mem_req = 1, go to BUSY_D.
  - Else if if_req & ~if_flush: latch if_addr with mem_we = 0, mem_req = 1, go to BUSY_I.
  - Else stay in IDLE.
  - When both requests are present in the same cycle, data is granted. The fetch waits and stall_if stays high.
- BUSY_D / BUSY_I:
  - mem_req and all mem_* outputs are held stable until mem_ready.
  - On mem_ready: mem_req drops next cycle and the FSM returns to IDLE.
  - No back-to-back issue. Minimum transaction is 3 cycles from req to valid, with memory latency L = 1.
- Responses:
  - BUSY_D + mem_ready: dm_rdata <= mem_rdata (loads only; stores leave dm_rdata unchanged). dm_valid pulses for exactly 1 cycle.
  - BUSY_I + mem_ready: if_rdata <= if_addr_latched[2] ? mem_rdata[63:32] : mem_rdata[31:0]. if_valid pulses for 1 cycle unless the fetch was killed.
- Flush:
  - if_flush in IDLE blocks fetch issue that cycle.
  - if_flush while in BUSY_I sets a kill bit. The transaction still completes on the memory side, but if_valid is suppressed and if_rdata is unchanged. The kill bit clears on return to IDLE.
  - A new fetch issues no earlier than the cycle after IDLE is re-entered.
- Requester drops req mid-transaction: the transaction completes and the valid pulse is still produced; the requester ignores it.
- Reset mid-transaction: the next edge forces IDLE and mem_req = 0; no valid pulse is produced. The memory aborts on mem_req falling.
- Starvation: fetch may starve under continuous dm_req. This is acceptable because the pipeline issues at most one data access per instruction.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUSY_* and increments each BUSY cycle.
  - If it reaches TIMEOUT without mem_ready: mem_req = 0, state returns to IDLE, and the requester's valid pulses with rdata = 0.
  - mem_err sets sticky and clears only on reset.
- Undefined: no counter; the arbiter waits indefinitely in BUSY; mem_err is tied 0.

Test Plan:
- Fetch only, L = 2, if_addr = 0x4, mem_rdata = 0xDEADBEEF_12345678 -> if_valid pulses once, 4 cycles after if_req rises; if_rdata = 0xDEADBEEF; stall_if is high until the pulse.
- Simultaneous if_req (addr 0x0) and dm_req load (addr 0x40, L = 2) -> data issues first; dm_valid with dm_rdata = mem data; the fetch then issues; if_valid arrives 4 cycles after dm_valid.
- Store: dm_we = 1, addr 0x80, wdata 0x55 -> mem_we = 1, mem_addr = 0x80, mem_wdata = 0x55 held stable until mem_ready; dm_valid pulses; dm_rdata unchanged.
- if_flush asserted 1 cycle into a fetch (L = 3) -> no if_valid pulse; if_rdata keeps its old value; the next fetch issues after IDLE is re-entered.
- Reset asserted while in BUSY_D -> next cycle mem_req = 0 and state = IDLE; neither valid pulses.
- With ARB_TIMEOUT_EN and TIMEOUT = 16, mem_ready never arrives -> at cycle 16 mem_req drops, dm_valid pulses with dm_rdata = 0, and mem_err = 1 sticky until reset.
